fir_dec_requant: RTL and testbench

//   Downstream stage of the transposed-form MCM FIR (20-bit registered output Y).

---
 rtl/fir_dec_requant_if.sv | 28 ++
 rtl/fir_dec_requant.sv | 156 +++++++++++++++
 tb/tb_fir_dec_requant.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_dec_requant_if.sv
// fir_dec_requant_if
//   Stream bundle between the FIR output, the decimating requantiser and the
//   downstream consumer.
//   in_vld / in_data   : FIR sample stream into the requantiser (no back-pressure)
//   out_vld / out_rdy  : valid/ready handshake on the buffered output
//   out_data           : signed FIFO head, stable while stalled
//   Modports: slave  = the requantiser itself
//             master = the environment that feeds samples and consumes results
interface fir_dec_requant_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 12
);
    logic                    in_vld;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_vld, in_data, out_rdy,
        input  out_vld, out_data
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output out_vld, out_data
    );
endinterface

// File: rtl/fir_dec_requant.sv
// fir_dec_requant
//   Downstream stage of the transposed-form FIR. Keeps one of every DEC valid
//   input samples, rescales by 2^-SHIFT with round-half-up, saturates to OUT_W
//   bits, and buffers results in a DEPTH-entry FIFO behind a valid/ready port.
//   Optional feature macro: FIR_DEC_SATCNT_EN (saturation event counter).
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous, active-low; clears all control state
//   bus       : fir_dec_requant_if.slave (in_vld/in_data, out_vld/out_rdy/out_data)
//   fifo_cnt  : FIFO occupancy 0..DEPTH
//   ovf       : sticky, a kept sample was dropped on a full FIFO
//   ovf_clr   : clears ovf (and sat_cnt when the counter is built)
//   sat_cnt   : saturation count, tied to zero unless FIR_DEC_SATCNT_EN
module fir_dec_requant #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 12,
    parameter int SHIFT = 8,
    parameter int DEC   = 6,
    parameter int PHASE = 0,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    fir_dec_requant_if.slave           bus,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic [15:0]                sat_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;

    localparam logic [PW-1:0]          PH_LAST  = PW'(DEC - 1);
    localparam logic [PW-1:0]          PH_KEEP  = PW'(PHASE);
    localparam logic signed [IN_W:0]   RND_HALF = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0]   SAT_HI   = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0]   SAT_LO   = ~SAT_HI;
    localparam logic [AW:0]            CNT_FULL = (AW+1)'(DEPTH);

    // One extra bit of headroom so adding the half-LSB never wraps.
    function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] ext;
        ext = {x[IN_W-1], x};
        return (ext + RND_HALF) >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] v);
        if (v > SAT_HI)
            return SAT_HI[OUT_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [IN_W:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    logic [PW-1:0]           ph;
    logic                    keep_p0;
    logic signed [IN_W:0]    rq_p0;

    logic                    vld_p1;
    logic signed [OUT_W-1:0] data_p1;

    logic signed [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    pop;
    logic                    full;
    logic                    push_ok;
    logic                    drop;

    // ---- stage 0: phase selection and requantisation ----
    assign keep_p0 = bus.in_vld && (ph == PH_KEEP);
    assign rq_p0   = round_shift(bus.in_data);

    // ---- stage 1: staged requantised sample ----
    // Data registers carry no reset; vld_p1 qualifies them.
    always_ff @(posedge clk) begin
        data_p1 <= saturate(rq_p0);
    end

    // ---- stage 2: FIFO push/pop ----
    assign pop     = bus.out_vld && bus.out_rdy;
    assign full    = (fifo_cnt == CNT_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_ok = vld_p1 && (!full || pop);
    assign drop    = vld_p1 && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= data_p1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ph       <= '0;
            vld_p1   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (bus.in_vld)
                ph <= (ph == PH_LAST) ? '0 : ph + PW'(1);
            vld_p1 <= keep_p0;
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // First-word-fall-through head; forced to zero while empty so that the
    // port reads zero after reset without resetting the storage array.
    assign bus.out_vld  = (fifo_cnt != '0);
    assign bus.out_data = bus.out_vld ? mem[rd_ptr] : '0;

`ifdef FIR_DEC_SATCNT_EN
    logic        sat_p1;
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        sat_p1 <= is_sat(rq_p0);
    end

    // Counted when the sample reaches the FIFO, whether or not it is dropped.
    // An increment coinciding with a clear restarts the count at 1.
    always_ff @(posedge clk) begin
        if (!reset)
            sat_cnt_q <= '0;
        else if (vld_p1 && sat_p1)
            sat_cnt_q <= ovf_clr ? 16'd1 :
                         (sat_cnt_q == 16'hFFFF) ? 16'hFFFF : sat_cnt_q + 16'd1;
        else if (ovf_clr)
            sat_cnt_q <= '0;
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fir_dec_requant.sv
// tb_fir_dec_requant
//   Three requantiser instances (DEC=6/PHASE=0, DEC=1, DEC=3/PHASE=2) share one
//   clock and reset. Stimulus pushes hand-computed results into per-instance
//   expectation queues; per-instance monitors pop and compare on every
//   out_vld & out_rdy. Direct checks cover reset state, latency, occupancy and
//   flags.
module tb_fir_dec_requant;
    logic clk;
    logic reset;

    logic [3:0]  cnt6, cnt1, cnt3;
    logic        ovf6, ovf1, ovf3;
    logic        clr6, clr1, clr3;
    logic [15:0] sc6, sc1, sc3;

    int vectors;
    int miscompares;

    int q6[$];
    int q1[$];
    int q3[$];

    fir_dec_requant_if #(.IN_W(20), .OUT_W(12)) b6();
    fir_dec_requant_if #(.IN_W(20), .OUT_W(12)) b1();
    fir_dec_requant_if #(.IN_W(20), .OUT_W(12)) b3();

    fir_dec_requant #(.DEC(6), .PHASE(0)) u6 (
        .clk(clk), .reset(reset), .bus(b6),
        .fifo_cnt(cnt6), .ovf(ovf6), .ovf_clr(clr6), .sat_cnt(sc6)
    );
    fir_dec_requant #(.DEC(1), .PHASE(0)) u1 (
        .clk(clk), .reset(reset), .bus(b1),
        .fifo_cnt(cnt1), .ovf(ovf1), .ovf_clr(clr1), .sat_cnt(sc1)
    );
    fir_dec_requant #(.DEC(3), .PHASE(2)) u3 (
        .clk(clk), .reset(reset), .bus(b3),
        .fifo_cnt(cnt3), .ovf(ovf3), .ovf_clr(clr3), .sat_cnt(sc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int w);
        case (w)
            6:       return q6.size();
            1:       return q1.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic int fcnt(input int w);
        case (w)
            6:       return int'(cnt6);
            1:       return int'(cnt1);
            default: return int'(cnt3);
        endcase
    endfunction

    task automatic drain(input string nm, input int w);
        int n;
        n = 0;
        repeat (3) tick();
        while ((qsize(w) != 0 || fcnt(w) != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_left"}, qsize(w), 0);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (b6.out_vld && b6.out_rdy) begin
            if (q6.size() == 0) chk("d6_extra", int'(b6.out_data), -99999);
            else                chk("d6_out", int'(b6.out_data), q6.pop_front());
        end
        if (b1.out_vld && b1.out_rdy) begin
            if (q1.size() == 0) chk("d1_extra", int'(b1.out_data), -99999);
            else                chk("d1_out", int'(b1.out_data), q1.pop_front());
        end
        if (b3.out_vld && b3.out_rdy) begin
            if (q3.size() == 0) chk("d3_extra", int'(b3.out_data), -99999);
            else                chk("d3_out", int'(b3.out_data), q3.pop_front());
        end
    end

    int t2_in[6]  = '{127, 128, -128, -129, 524287, -524288};
    int t2_exp[6] = '{0, 1, 0, -1, 2047, -2048};

    initial begin
        int v;
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        b6.in_vld = 1'b0; b6.in_data = '0; b6.out_rdy = 1'b1; clr6 = 1'b0;
        b1.in_vld = 1'b0; b1.in_data = '0; b1.out_rdy = 1'b1; clr1 = 1'b0;
        b3.in_vld = 1'b0; b3.in_data = '0; b3.out_rdy = 1'b1; clr3 = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_vld",  int'(b6.out_vld), 0);
        chk("rst_data", int'(b6.out_data), 0);
        chk("rst_cnt",  int'(cnt6), 0);
        chk("rst_ovf",  int'(ovf6), 0);
        chk("rst_sat",  int'(sc1), 0);
        reset = 1'b1;

        // Ramp through DEC=6
        for (int k = 0; k < 60; k++) begin
            b6.in_vld  = 1'b1;
            b6.in_data = 20'(k << 8);
            if (k % 6 == 0) q6.push_back(k);
            tick();
            if (k == 0) chk("t1_lat_e0", int'(b6.out_vld), 0);
            if (k == 1) chk("t1_lat_e1", int'(b6.out_vld), 1);
        end
        b6.in_vld = 1'b0;
        drain("t1", 6);

        // Rounding and saturation, DEC=1
        for (int i = 0; i < 6; i++) begin
            b1.in_vld  = 1'b1;
            b1.in_data = 20'(t2_in[i]);
            q1.push_back(t2_exp[i]);
            tick();
        end
        b1.in_vld = 1'b0;
        drain("t2", 1);
`ifdef FIR_DEC_SATCNT_EN
        chk("t2_satcnt", int'(sc1), 1);
`else
        chk("t2_satcnt", int'(sc1), 0);
`endif

        // Overflow with stalled consumer
        b1.out_rdy = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            b1.in_vld  = 1'b1;
            b1.in_data = 20'(i << 8);
            if (i <= 8) q1.push_back(i);
            tick();
        end
        b1.in_vld = 1'b0;
        repeat (2) tick();
        chk("t3_cnt",  int'(cnt1), 8);
        chk("t3_ovf",  int'(ovf1), 1);
        chk("t3_head", int'(b1.out_data), 1);
        repeat (3) tick();
        chk("t3_hold", int'(b1.out_data), 1);
        b1.out_rdy = 1'b1;
        drain("t3", 1);
        chk("t3_ovf_sticky", int'(ovf1), 1);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("t3_ovf_clr", int'(ovf1), 0);

        // Full FIFO with push and pop every cycle
        b1.out_rdy = 1'b0;
        for (int i = 0; i < 29; i++) begin
            if (i == 9) b1.out_rdy = 1'b1;
            b1.in_vld  = 1'b1;
            b1.in_data = 20'((20 + i) << 8);
            q1.push_back(20 + i);
            tick();
            if (i >= 8) begin
                chk("t4_cnt", int'(cnt1), 8);
                chk("t4_ovf", int'(ovf1), 0);
            end
        end
        b1.in_vld = 1'b0;
        drain("t4", 1);

        // Mid-stream reset with 5 buffered samples
        b6.out_rdy = 1'b0;
        for (int j = 0; j < 28; j++) begin
            b6.in_vld  = 1'b1;
            b6.in_data = 20'((60 + j) << 8);
            tick();
        end
        b6.in_vld = 1'b0;
        repeat (2) tick();
        chk("t5_pre_cnt", int'(cnt6), 5);
        reset      = 1'b0;
        b6.in_vld  = 1'b1;
        b6.in_data = 20'(99 << 8);
        tick();
        reset      = 1'b1;
        b6.in_vld  = 1'b0;
        chk("t5_vld",  int'(b6.out_vld), 0);
        chk("t5_cnt",  int'(cnt6), 0);
        chk("t5_ovf",  int'(ovf6), 0);
        chk("t5_data", int'(b6.out_data), 0);
        b6.out_rdy = 1'b1;
        for (int j = 0; j < 7; j++) begin
            b6.in_vld  = 1'b1;
            b6.in_data = 20'((40 + j) << 8);
            if (j == 0 || j == 6) q6.push_back(40 + j);
            tick();
        end
        b6.in_vld = 1'b0;
        drain("t5", 6);

        // Gapped input, DEC=3 PHASE=2
        v = 0;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) begin
                b3.in_vld  = 1'b1;
                b3.in_data = 20'((10 + v) << 8);
                if (v % 3 == 2) q3.push_back(10 + v);
                v++;
            end else begin
                b3.in_vld  = 1'b0;
                b3.in_data = 20'h7FFFF;
            end
            tick();
        end
        b3.in_vld = 1'b0;
        drain("t6", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
